// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential, jump, branch, call and return modes backed by a circular return-address stack
module pc_unit #(
  parameter int                 WIDTH     = 16,
  parameter int                 INC       = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   sel,
  input  logic [WIDTH-1:0]             jump_addr,
  input  logic [WIDTH-1:0]             offset,
  input  logic                         taken,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         illegal
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] pc_q, pc_d, seq;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  logic             full, empty, is_call, is_ret, push, pop;
  always_comb begin
    seq     = pc_q + WIDTH'(INC);
    full    = cnt_q == CW'(RAS_DEPTH);
    empty   = cnt_q == '0;
    is_call = sel == 3'b011;
    is_ret  = sel == 3'b100;
    pc_next = (sel == 3'b001 || is_call) ? jump_addr :
              (sel == 3'b010 && taken)   ? seq + offset :
              (is_ret && !empty)         ? ras_q[top_q] : seq;
    push    = is_call && !stall;
    pop     = is_ret && !stall && !empty;
    // Pushing when full lands on top+1, which is exactly the oldest slot.
    top_d   = push ? top_q + PW'(1) : pop ? top_q - PW'(1) : top_q;
    cnt_d   = push ? (full ? cnt_q : cnt_q + CW'(1)) : pop ? cnt_q - CW'(1) : cnt_q;
    pc_d    = stall ? pc_q : pc_next;
    ovf_d   = push && full;
    unf_d   = is_ret && !stall && empty;
    ill_d   = sel[2] && (sel[1] || sel[0]) && !stall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ill_q <= ill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[top_d] <= seq;
  end
  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign illegal       = ill_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit at default parameters and at a wide/shallow-increment/deep-RAS configuration
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst, stall, taken;
  logic [2:0]  sel;
  logic [31:0] jump_addr, offset;
  logic [15:0] pc0, pcn0;
  logic [2:0]  cnt0;
  logic        ovf0, unf0, ill0;
  logic [31:0] pc1, pcn1;
  logic [3:0]  cnt1;
  logic        ovf1, unf1, ill1;
  logic        ph = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  pc_unit dut0 (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel),
    .jump_addr(jump_addr[15:0]), .offset(offset[15:0]), .taken(taken),
    .pc(pc0), .pc_next(pcn0), .ras_count(cnt0),
    .ras_overflow(ovf0), .ras_underflow(unf0), .illegal(ill0)
  );

  pc_unit #(.WIDTH(32), .INC(2), .RESET_VEC(32'h1000), .RAS_DEPTH(8)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel),
    .jump_addr(jump_addr), .offset(offset), .taken(taken),
    .pc(pc1), .pc_next(pcn1), .ras_count(cnt1),
    .ras_overflow(ovf1), .ras_underflow(unf1), .illegal(ill1)
  );

  function automatic logic [31:0] o_pc();
    return ph ? pc1 : {16'h0, pc0};
  endfunction
  function automatic logic [31:0] o_pcn();
    return ph ? pcn1 : {16'h0, pcn0};
  endfunction
  function automatic logic [31:0] o_cnt();
    return ph ? {28'h0, cnt1} : {29'h0, cnt0};
  endfunction
  function automatic logic [31:0] o_flags();
    return ph ? {29'h0, ovf1, unf1, ill1} : {29'h0, ovf0, unf0, ill0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] ja, input logic [31:0] off, input logic tk);
    sel = s; jump_addr = ja; offset = off; taken = tk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [2:0] s, input logic [31:0] ja, input logic [31:0] off, input logic tk);
    drive(s, ja, off, tk);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3'b000, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(3'b000, 0, 0, 0);
    @(posedge clk); #1;

    // default configuration: WIDTH 16, INC 4, RESET_VEC 0, RAS_DEPTH 4
    do_reset();
    chk("a_rst_pc", o_pc(), 32'h0);
    chk("a_rst_cnt", o_cnt(), 0);
    chk("a_rst_flags", o_flags(), 0);
    step(3'b000, 0, 0, 0); chk("a_seq1", o_pc(), 32'h4);
    step(3'b000, 0, 0, 0); chk("a_seq2", o_pc(), 32'h8);
    step(3'b000, 0, 0, 0); chk("a_seq3", o_pc(), 32'hC);
    chk("a_seq_flags", o_flags(), 0);
    chk("a_seq_cnt", o_cnt(), 0);
    step(3'b001, 32'h10, 0, 0); chk("a_jump", o_pc(), 32'h10);
    drive(3'b010, 0, 32'hFFF8, 1); chk("a_br_t_next", o_pcn(), 32'hC);
    tick(); chk("a_br_t", o_pc(), 32'hC);
    step(3'b001, 32'h10, 0, 0);
    step(3'b010, 0, 32'hFFF8, 0); chk("a_br_nt", o_pc(), 32'h14);
    step(3'b001, 32'hFFFC, 0, 0);
    step(3'b000, 0, 0, 0); chk("a_wrap", o_pc(), 32'h0);
    step(3'b001, 32'h100, 0, 0);
    step(3'b011, 32'h200, 0, 0); chk("a_call1_pc", o_pc(), 32'h200); chk("a_call1_cnt", o_cnt(), 1);
    step(3'b011, 32'h300, 0, 0); chk("a_call2_pc", o_pc(), 32'h300); chk("a_call2_cnt", o_cnt(), 2);
    step(3'b100, 0, 0, 0); chk("a_ret1", o_pc(), 32'h204); chk("a_ret1_cnt", o_cnt(), 1);
    step(3'b100, 0, 0, 0); chk("a_ret2", o_pc(), 32'h104); chk("a_ret2_cnt", o_cnt(), 0);
    // overflow: five calls into a four-deep stack drop the oldest return (0x0004)
    step(3'b001, 32'h0, 0, 0);
    for (int k = 1; k <= 4; k++) step(3'b011, 32'(k * 16), 0, 0);
    chk("a_ovf_pre", o_flags(), 0);
    chk("a_ovf_pre_cnt", o_cnt(), 4);
    step(3'b011, 32'h50, 0, 0);
    chk("a_ovf", o_flags(), 32'b100);
    chk("a_ovf_cnt", o_cnt(), 4);
    step(3'b100, 0, 0, 0); chk("a_oret1", o_pc(), 32'h44); chk("a_ovf_clr", o_flags(), 0);
    step(3'b100, 0, 0, 0); chk("a_oret2", o_pc(), 32'h34);
    step(3'b100, 0, 0, 0); chk("a_oret3", o_pc(), 32'h24);
    step(3'b100, 0, 0, 0); chk("a_oret4", o_pc(), 32'h14); chk("a_oret_cnt", o_cnt(), 0);
    step(3'b100, 0, 0, 0); chk("a_unf_pc", o_pc(), 32'h18); chk("a_unf", o_flags(), 32'b010);
    step(3'b000, 0, 0, 0); chk("a_unf_clr", o_flags(), 0);
    // stall holds PC and RAS while pc_next still follows the inputs
    step(3'b001, 32'h20, 0, 0);
    stall = 1'b1;
    drive(3'b011, 32'h80, 0, 0); chk("a_stall_next", o_pcn(), 32'h80);
    tick(); chk("a_stall_pc", o_pc(), 32'h20); chk("a_stall_cnt", o_cnt(), 0); chk("a_stall_flags", o_flags(), 0);
    stall = 1'b0;
    step(3'b110, 0, 0, 0); chk("a_ill_pc", o_pc(), 32'h24); chk("a_ill", o_flags(), 32'b001);
    step(3'b000, 0, 0, 0); chk("a_ill_clr", o_flags(), 0); chk("a_ill_after", o_pc(), 32'h28);
    // reset together with a return: no pop, no underflow, pointers cleared
    step(3'b011, 32'h100, 0, 0);
    step(3'b011, 32'h200, 0, 0);
    step(3'b011, 32'h300, 0, 0); chk("a_pre_rst_cnt", o_cnt(), 3);
    rst = 1'b1;
    step(3'b100, 0, 0, 0);
    rst = 1'b0;
    chk("a_mid_rst_pc", o_pc(), 32'h0); chk("a_mid_rst_cnt", o_cnt(), 0); chk("a_mid_rst_flags", o_flags(), 0);
    step(3'b100, 0, 0, 0); chk("a_post_rst_unf", o_flags(), 32'b010); chk("a_post_rst_pc", o_pc(), 32'h4);

    // wide configuration: WIDTH 32, INC 2, RESET_VEC 0x1000, RAS_DEPTH 8
    ph = 1'b1;
    do_reset();
    chk("b_rst_pc", o_pc(), 32'h1000);
    chk("b_rst_cnt", o_cnt(), 0);
    step(3'b000, 0, 0, 0); chk("b_seq1", o_pc(), 32'h1002);
    step(3'b000, 0, 0, 0); chk("b_seq2", o_pc(), 32'h1004);
    step(3'b000, 0, 0, 0); chk("b_seq3", o_pc(), 32'h1006);
    step(3'b001, 32'h10, 0, 0);
    step(3'b010, 0, 32'hFFFF_FFF8, 1); chk("b_br_t", o_pc(), 32'hA);
    step(3'b001, 32'h10, 0, 0);
    step(3'b010, 0, 32'hFFFF_FFF8, 0); chk("b_br_nt", o_pc(), 32'h12);
    step(3'b001, 32'hFFFF_FFFE, 0, 0);
    step(3'b000, 0, 0, 0); chk("b_wrap", o_pc(), 32'h0);
    step(3'b001, 32'h100, 0, 0);
    step(3'b011, 32'h200, 0, 0); chk("b_call1_cnt", o_cnt(), 1);
    step(3'b011, 32'h300, 0, 0); chk("b_call2_cnt", o_cnt(), 2);
    step(3'b100, 0, 0, 0); chk("b_ret1", o_pc(), 32'h202);
    step(3'b100, 0, 0, 0); chk("b_ret2", o_pc(), 32'h102); chk("b_ret2_cnt", o_cnt(), 0);
    step(3'b001, 32'h0, 0, 0);
    for (int k = 1; k <= 8; k++) step(3'b011, 32'(k * 16), 0, 0);
    chk("b_ovf_pre", o_flags(), 0);
    chk("b_full_cnt", o_cnt(), 8);
    step(3'b011, 32'h90, 0, 0);
    chk("b_ovf", o_flags(), 32'b100);
    chk("b_ovf_cnt", o_cnt(), 8);
    step(3'b100, 0, 0, 0); chk("b_ovf_ret", o_pc(), 32'h82);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: owns the architectural PC register and computes the next fetch address each cycle. It supports sequential increment, absolute jump, PC-relative branch, call and return. Call and return use an internal return-address stack (RAS). It sits at the head of the fetch stage, feeding instruction memory and the `adder16bit`-based datapath. It supersedes the unregistered, 16-bit-only adjust logic.

## Interface
Parameters:
- `WIDTH`, 16, address width in bits
- `INC`, 4, sequential increment (bytes per instruction)
- `RESET_VEC`, 0, PC value loaded on reset
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold PC and RAS this cycle
- `sel`  in  3  mode: 000 seq, 001 jump, 010 branch, 011 call, 100 return, others illegal
- `jump_addr`  in  WIDTH  absolute target for jump/call
- `offset`  in  WIDTH  signed two's-complement branch displacement
- `taken`  in  1  branch condition, used only when `sel`=010
- `pc`  out  WIDTH  current PC (registered)
- `pc_next`  out  WIDTH  combinational value `pc` takes at next unstalled edge
- `ras_count`  out  clog2(RAS_DEPTH)+1  valid RAS entries
- `ras_overflow`  out  1  one-cycle pulse: call while RAS full
- `ras_underflow`  out  1  one-cycle pulse: return while RAS empty
- `illegal`  out  1  one-cycle pulse: `sel` ∈ {101,110,111}

## Operation
- `seq` = `pc` + `INC`. All arithmetic is modulo 2^WIDTH, with no carry out.
- `pc_next` by `sel`:
  - 000: `seq`.
  - 001: `jump_addr`.
  - 010: `seq` + `offset` if `taken`, else `seq`.
  - 011 call: `jump_addr`. Push `seq` onto the RAS.
  - 100 return: top of RAS, which is then popped. If the RAS is empty, `seq`.
  - illegal: `seq`. No RAS change.
- RAS is a circular buffer with a top pointer and a count.
  - Push when `ras_count` < RAS_DEPTH: write at top+1, count+1.
  - Push when full: overwrite the oldest entry (top advances, wrapping), count stays RAS_DEPTH, assert `ras_overflow`.
  - Pop when count>0: read top, top−1 (wrapping), count−1.
  - Pop when empty: no pointer change, assert `ras_underflow`.
- `stall`=1:
  - `pc`, RAS contents, pointer and count hold.
  - `pc_next` still reflects the inputs.
  - `ras_overflow`, `ras_underflow` and `illegal` are 0.
- Reset (`rst`=1 at an edge):
  - `pc`=RESET_VEC, `ras_count`=0, top pointer=0.
  - All flags 0.
  - Reset overrides `stall` and any in-progress mode. RAS contents are don't-care.

## Timing
- Single rising-edge domain. `pc` updates at the edge where `rst`=0 and `stall`=0, taking the `pc_next` computed from that cycle's inputs.
- Latency from `sel`/target inputs to `pc` is 1 cycle. `pc_next` has 0 latency (combinational from `pc`, inputs and RAS top).
- Flags are registered. They are high for exactly the cycle after the offending unstalled edge, then return to 0 unless re-triggered.
- Back-to-back call/return on consecutive cycles is legal:
  - A return immediately after a call yields the pushed `seq`.
  - A call immediately after a return pushes onto the post-pop state.
- `rst` asserted in the same cycle as a call/return: the reset wins and no push/pop occurs.
- Wrap-around: `pc`=2^WIDTH−INC with seq gives 0. A negative `offset` wraps modulo 2^WIDTH.

## Test plan
- Reset/seq: hold `rst` 2 cycles, then `sel`=000 for 3 cycles → `pc` 0x0000, 0x0004, 0x0008, 0x000C. Flags and `ras_count` stay 0.
- Branch:
  - At `pc`=0x0010, `sel`=010, `offset`=0xFFF8 (−8), `taken`=1 → `pc`=0x000C.
  - Same with `taken`=0 → 0x0014.
  - At `pc`=0xFFFC, seq → 0x0000.
- Call/return nesting:
  - From `pc`=0x0100, call 0x0200 → `pc`=0x0200, `ras_count`=1.
  - Call 0x0300 → `ras_count`=2.
  - Return → 0x0204. Return → 0x0104, `ras_count`=0.
- RAS overflow/underflow (RAS_DEPTH=4):
  - 5 calls from `pc`=0x0000 to 0x0010, 0x0020, 0x0030, 0x0040, 0x0050 → `ras_overflow` pulses after the 5th, `ras_count`=4.
  - Then 4 returns → 0x0044, 0x0034, 0x0024, 0x0014.
  - A 5th return → `pc`=0x0018, `ras_underflow` pulses.
- Stall and illegal:
  - Stall during a call at `pc`=0x0020 → `pc` and `ras_count` unchanged, `pc_next`=`jump_addr`.
  - `sel`=110 unstalled → `pc`=0x0024, `illegal` high for one cycle.
- Reset mid-operation: with `ras_count`=3, assert `rst` together with `sel`=100 → `pc`=RESET_VEC, `ras_count`=0, no underflow pulse.
- Parameter sweep: repeat the first three scenarios with WIDTH=32, INC=2, RESET_VEC=0x1000, RAS_DEPTH=8.
